delay_responder: RTL and testbench

Responder end of the overlapped request/response check `valid |-> (a ##DELAY b)`. Each cycle in which `valid && a` is sampled at a rising clock edge is a request. For each request, the block drives a one-cycle response pulse on `b` that is sampled high exactly `DELAY` edges later, carrying the request's tag. It sits opposite the request generator in the team's assertion benches. It acts as a protocol-correct DUT, so the overlapped-implication property holds by construction for back-to-back, overlapping and flushed traffic.

---
 rtl/delay_responder_pkg.sv | 18 +
 rtl/rsp_shift_stage.sv | 37 +++
 rtl/delay_responder.sv | 122 ++++++++++++
 tb/tb_delay_responder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/delay_responder_pkg.sv
// delay_responder_pkg: shared types and helpers for the delay_responder block.
// Stage records carry a full MAX_TAG_W tag field. Narrower tags are zero-extended
// on entry, and the unused upper bits are constant zero.
package delay_responder_pkg;

    localparam int MAX_DELAY = 16;
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic                 vld;
        logic [MAX_TAG_W-1:0] tag;
    } rsp_stage_t;

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/rsp_shift_stage.sv
// rsp_shift_stage: one slot of the response delay line.
// Each stage is a registered {vld, tag} record. The record is cleared by a
// synchronous active-low reset, or by 'clr', which the top drives with flush
// for every stage except the head.
module rsp_shift_stage
    import delay_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  rsp_stage_t d,
    output rsp_stage_t q
);

    rsp_stage_t stage_d;
    rsp_stage_t stage_q;

    // Next stage value: take the upstream record unless this stage is being flushed
    always_comb begin
        stage_d = d;
        if (clr) begin
            stage_d = '0;
        end
    end

    // Stage register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/delay_responder.sv
// delay_responder: responder side of the overlapped check valid |-> (a ##DELAY b).
// A request is valid && a at a posedge. It travels through DELAY stages and
// appears on b/b_tag so that it is sampled exactly DELAY edges later.
// Optional build macro: DELAY_RESPONDER_SVA_EN. It embeds the response
// assertion, a back-to-back cover and an outstanding-range check. RTL behaviour
// is the same with or without the macro.
module delay_responder
    import delay_responder_pkg::*;
#(
    parameter int DELAY = 3,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic                       a,
    input  logic [TAG_W-1:0]           a_tag,
    input  logic                       flush,
    output logic                       b,
    output logic [TAG_W-1:0]           b_tag,
    output logic [$clog2(DELAY+1)-1:0] outstanding,
    output logic                       busy
);

    localparam int CNT_W = cnt_w(DELAY);

    logic             accept;
    logic             issue;
    rsp_stage_t       head_d;
    rsp_stage_t       stage_out [DELAY];
    logic [CNT_W-1:0] outstanding_d;
    logic [CNT_W-1:0] outstanding_q;
    logic             unused_tag_bits;

    assign accept = valid && a;
    assign issue  = stage_out[DELAY-1].vld;

    // Head record: an accepted request with its tag, otherwise a bubble with tag 0
    always_comb begin
        head_d = '0;
        if (accept) begin
            head_d.vld = 1'b1;
            head_d.tag = MAX_TAG_W'(a_tag);
        end
    end

    // Delay line. The head always loads, so a request that arrives with a flush
    // survives. Later stages are cleared by flush.
    for (genvar i = 0; i < DELAY; i++) begin : g_stage
        if (i == 0) begin : g_head
            rsp_shift_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (1'b0),
                .d     (head_d),
                .q     (stage_out[i])
            );
        end else begin : g_body
            rsp_shift_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (flush),
                .d     (stage_out[i-1]),
                .q     (stage_out[i])
            );
        end
    end

    // Outstanding count tracks the number of valid stages. A flush leaves only
    // the request accepted on that edge.
    always_comb begin
        outstanding_d = outstanding_q;
        if (flush) begin
            outstanding_d = CNT_W'(accept);
        end else if (accept && !issue) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && issue) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    // Outstanding register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign b               = stage_out[DELAY-1].vld;
    assign b_tag           = stage_out[DELAY-1].tag[TAG_W-1:0];
    assign outstanding     = outstanding_q;
    assign busy            = (outstanding_q != '0);
    assign unused_tag_bits = ^stage_out[DELAY-1].tag;

`ifdef DELAY_RESPONDER_SVA_EN
    property p_response;
        @(posedge clk) disable iff (!rst_n || flush)
            (valid && a) |-> ##DELAY b;
    endproperty

    a_response : assert property (p_response)
        else $error("delay_responder: missing response at %0t for tag %0h",
                    $time, $past(a_tag, DELAY));

    c_back_to_back : cover property (
        @(posedge clk) disable iff (!rst_n)
            (valid && a) ##1 (valid && a));

    // The occupancy can never exceed the number of stages
    always @(posedge clk) begin
        if (rst_n) begin
            a_outstanding_range : assert (outstanding_q <= CNT_W'(DELAY))
                else $error("delay_responder: outstanding %0d above DELAY at %0t (tag %0h)",
                            outstanding_q, $time, b_tag);
        end
    end
`else
`endif

endmodule

// File: tb/tb_delay_responder.sv
// tb_delay_responder: directed and random check of delay_responder (DELAY=3, TAG_W=4).
// A queue of pending responses, keyed by due edge, predicts the outputs.
module tb_delay_responder;

    localparam int DELAY = 3;
    localparam int TAG_W = 4;
    localparam int CNT_W = $clog2(DELAY + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    logic             a     = 1'b0;
    logic [TAG_W-1:0] a_tag = '0;
    logic             flush = 1'b0;
    logic             b;
    logic [TAG_W-1:0] b_tag;
    logic [CNT_W-1:0] outstanding;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
    } pend_t;

    pend_t            pend[$];
    int               edge_cnt    = 0;
    bit               model_ready = 1'b0;
    logic             m_b;
    logic [TAG_W-1:0] m_tag;

    delay_responder #(.DELAY(DELAY), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid       (valid),
        .a           (a),
        .a_tag       (a_tag),
        .flush       (flush),
        .b           (b),
        .b_tag       (b_tag),
        .outstanding (outstanding),
        .busy        (busy)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: each accepted request is due DELAY edges later. A flush cancels
    // everything not yet sampled, and a reset cancels everything.
    always @(posedge clk) begin
        edge_cnt++;
        if (!rst_n) begin
            pend.delete();
            model_ready = 1'b1;
        end else begin
            while (pend.size() > 0 && pend[0].due <= edge_cnt) begin
                void'(pend.pop_front());
            end
            if (flush) begin
                pend.delete();
            end
            if (valid && a) begin
                pend.push_back('{due: edge_cnt + DELAY, tag: a_tag});
            end
        end
    end

    // Compare every cycle, after the edge, against what the next edge must sample
    always @(negedge clk) begin
        if (model_ready) begin
            m_b   = 1'b0;
            m_tag = '0;
            foreach (pend[i]) begin
                if (pend[i].due == edge_cnt + 1) begin
                    m_b   = 1'b1;
                    m_tag = pend[i].tag;
                end
            end
            compareValue("model b", 32'(b), 32'(m_b));
            compareValue("model b_tag", 32'(b_tag), 32'(m_tag));
            compareValue("model outstanding", 32'(outstanding), 32'(pend.size()));
            compareValue("model busy", 32'(busy), 32'(pend.size() != 0));
        end
    end

    // Hard stop in case the stimulus never completes
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one edge worth of inputs, then return just after the following negedge
    task automatic applyStimulus(input logic rst_v, input logic v, input logic aa,
                                 input logic [TAG_W-1:0] tag, input logic fl);
        rst_n = rst_v;
        valid = v;
        a     = aa;
        a_tag = tag;
        flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic exp_b,
                               input logic [TAG_W-1:0] exp_tag, input int exp_out);
        compareValue({name, " b"}, 32'(b), 32'(exp_b));
        compareValue({name, " b_tag"}, 32'(b_tag), 32'(exp_tag));
        compareValue({name, " outstanding"}, 32'(outstanding), 32'(exp_out));
        compareValue({name, " busy"}, 32'(busy), 32'(exp_out != 0));
    endtask

    // Directed scenarios (edge 1 is reset; each check reads outputs after the edge,
    // i.e. the value the following edge samples), then random traffic
    initial begin
        // single request at edge 2, tag 5: sampled at edge 5
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s1 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h5, 1'b0); checkOutput("s1 e2", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s1 e3", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s1 e4", 1'b1, 4'h5, 1);
        idle();                                       checkOutput("s1 e5", 1'b0, 4'h0, 0);

        // back-to-back requests at edges 2..4, tags 1..3
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s2 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 1'b0); checkOutput("s2 e2", 1'b0, 4'h0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h2, 1'b0); checkOutput("s2 e3", 1'b0, 4'h0, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h3, 1'b0); checkOutput("s2 e4", 1'b1, 4'h1, 3);
        idle();                                       checkOutput("s2 e5", 1'b1, 4'h2, 2);
        idle();                                       checkOutput("s2 e6", 1'b1, 4'h3, 1);
        idle();                                       checkOutput("s2 e7", 1'b0, 4'h0, 0);

        // a without valid at edge 4 is not a request
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s3 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h6, 1'b0); checkOutput("s3 e2", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s3 e3", 1'b0, 4'h0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'h7, 1'b0); checkOutput("s3 e4", 1'b1, 4'h6, 1);
        idle();                                       checkOutput("s3 e5", 1'b0, 4'h0, 0);
        idle();                                       checkOutput("s3 e6", 1'b0, 4'h0, 0);

        // flush at edge 3 with a new request tag 9
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s4 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h4, 1'b0); checkOutput("s4 e2", 1'b0, 4'h0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h9, 1'b1); checkOutput("s4 e3", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s4 e4", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s4 e5", 1'b1, 4'h9, 1);
        idle();                                       checkOutput("s4 e6", 1'b0, 4'h0, 0);

        // reset at edge 4 drops in-flight and same-edge requests
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s5 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h1, 1'b0); checkOutput("s5 e2", 1'b0, 4'h0, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h2, 1'b0); checkOutput("s5 e3", 1'b0, 4'h0, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'h3, 1'b0); checkOutput("s5 e4", 1'b0, 4'h0, 0);
        idle();                                       checkOutput("s5 e5", 1'b0, 4'h0, 0);
        idle();                                       checkOutput("s5 e6", 1'b0, 4'h0, 0);

        // flush on the edge where a response is already in the last stage
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);  checkOutput("s6 reset", 1'b0, 4'h0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hA, 1'b0); checkOutput("s6 e2", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s6 e3", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s6 e4", 1'b1, 4'hA, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'hB, 1'b1); checkOutput("s6 e5", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s6 e6", 1'b0, 4'h0, 1);
        idle();                                       checkOutput("s6 e7", 1'b1, 4'hB, 1);
        idle();                                       checkOutput("s6 e8", 1'b0, 4'h0, 0);

        // random traffic, checked against the model on every cycle
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 49) != 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 2) != 0,
                          TAG_W'($urandom),
                          $urandom_range(0, 15) == 0);
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
